// File: rtl/bmp_pkg.sv
// bmp_pkg: shared definitions for the BMP stream parser.
//   - bmp_state_e     : parser FSM state encoding
//   - BMP_SIG0/1      : the "BM" file signature bytes
//   - OFS_*           : file byte offsets of the captured header fields
//   - MIN_HDR_BYTES   : smallest legal pixel-data offset
//   - lanes01_le/23_le: pull a little-endian 16-bit value out of two byte
//                       lanes of a stream word (lane 0 = first byte = MSB)
package bmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_PIXEL = 2'd2,
    ST_ERR   = 2'd3
  } bmp_state_e;

  localparam logic [7:0] BMP_SIG0 = 8'h42;
  localparam logic [7:0] BMP_SIG1 = 8'h4D;

  localparam int unsigned OFS_FILE_SIZE   = 2;
  localparam int unsigned OFS_DATA_OFFSET = 10;
  localparam int unsigned OFS_IMG_WIDTH   = 18;
  localparam int unsigned OFS_IMG_HEIGHT  = 22;
  localparam int unsigned OFS_BIT_COUNT   = 28;

  localparam int unsigned MIN_HDR_BYTES = 54;

  // Lanes 0,1 hold file bytes 4k, 4k+1; lane 0 is the low byte of the value.
  function automatic logic [15:0] lanes01_le(input logic [31:0] w);
    return {w[23:16], w[31:24]};
  endfunction

  // Lanes 2,3 hold file bytes 4k+2, 4k+3; lane 2 is the low byte.
  function automatic logic [15:0] lanes23_le(input logic [31:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/bmp_out_slice.sv
// bmp_out_slice: one-entry valid/ready register stage carrying a stream word,
// its per-byte pixel mask and its last flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high, on either side. ld_ready_o = !out_valid_o || out_ready_i, so a
// held word may drain and a new one load on the same edge; while
// out_valid_o && !out_ready_i all out_* stay stable.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   ld_valid_i/ld_ready_o            load side handshake
//   ld_data_i/ld_mask_i/ld_last_i    load payload
//   out_valid_o/out_ready_i          drain side handshake
//   out_data_o/out_mask_o/out_last_o held payload
module bmp_out_slice #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic [3:0]            ld_mask_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [3:0]            out_mask_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            mask_q, mask_d;
  logic                  last_q, last_d;

  always_comb begin
    ld_ready_o = !valid_q || out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    if (ld_ready_o) begin
      valid_d = ld_valid_i;
      // Payload only changes on a real load, so a drained stage keeps
      // showing its last word rather than toggling on idle input.
      if (ld_valid_i) begin
        data_d = ld_data_i;
        mask_d = ld_mask_i;
        last_d = ld_last_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_mask_o  = mask_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/bmp_stream_parser.sv
// bmp_stream_parser: accepts a BMP file as 32-bit words (first file byte in
// the MSB), validates the signature and pixel offset, captures the header
// fields and forwards every valid word one cycle later, tagged with a
// per-byte pixel mask and an end-of-file flag.
//
// Handshake: input word taken on an edge with in_valid && in_ready; output
// word taken on an edge with out_valid && out_ready. Outside the error state
// in_ready = !out_valid || out_ready; in the error state in_ready = 1 and
// everything is discarded.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_data/in_valid/in_ready           input word stream
//   out_data/out_valid/out_ready        forwarded word stream
//   out_pix_mask                        bit j: byte out_data[8j+7:8j] is pixel
//   out_last                            word holds byte file_size-1
//   file_size, data_offset, img_width,
//   img_height, bit_count               captured header fields
//   hdr_valid                           all fields captured for this file
//   err                                 sticky format error
//   dbg_state                           current FSM state
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MIN_HDR_BYTES = bmp_pkg::MIN_HDR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_pix_mask,
  output logic                  out_last,
  output logic [31:0]           file_size,
  output logic [31:0]           data_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic [15:0]           bit_count,
  output logic                  hdr_valid,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  // Word indices holding each field. Fields at offsets 4k+2 start in lanes
  // 2,3 of word k and finish in lanes 0,1 of word k+1.
  localparam logic [29:0] W_FS  = 30'(OFS_FILE_SIZE / 4);
  localparam logic [29:0] W_DO  = 30'(OFS_DATA_OFFSET / 4);
  localparam logic [29:0] W_IW  = 30'(OFS_IMG_WIDTH / 4);
  localparam logic [29:0] W_IH  = 30'(OFS_IMG_HEIGHT / 4);
  localparam logic [29:0] W_BC  = 30'(OFS_BIT_COUNT / 4);
  localparam logic [29:0] W_CHK = W_DO + 30'd1;

  bmp_state_e  state_q, state_d;
  logic [31:0] byte_addr_q, byte_addr_d;
  logic [31:0] file_size_q, file_size_d;
  logic [31:0] data_offset_q, data_offset_d;
  logic [31:0] img_width_q, img_width_d;
  logic [31:0] img_height_q, img_height_d;
  logic [15:0] bit_count_q, bit_count_d;
  logic        hdr_valid_q, hdr_valid_d;

  logic        slice_ready;
  logic        accept;
  logic        fwd;
  logic [29:0] word_idx;
  logic        sig_ok;
  logic [31:0] doff_full;
  logic        offset_bad;
  logic        in_body;
  logic [31:0] addr_next;
  logic        is_last;
  logic [3:0]  pix_mask;

  assign in_ready  = (state_q == ST_ERR) ? 1'b1 : slice_ready;
  assign accept    = in_valid && in_ready;
  assign word_idx  = byte_addr_q[31:2];
  assign addr_next = byte_addr_q + 32'd4;
  assign sig_ok    = (in_data[31:24] == BMP_SIG0) && (in_data[23:16] == BMP_SIG1);

  // Offset check on the word completing data_offset, using its new upper half.
  assign doff_full  = {lanes01_le(in_data), data_offset_q[15:0]};
  assign offset_bad = (doff_full < MIN_HDR_BYTES) || (file_size_q <= doff_full);

  // Past the offset-check word both file_size and data_offset are complete
  // and validated; before that the registers may still hold the previous
  // file's values, so mask, last and the PIXEL transition are gated off.
  assign in_body = (word_idx > W_CHK);
  assign is_last = in_body && (addr_next >= file_size_q);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [31:0] lane_addr;
    assign lane_addr       = byte_addr_q + 32'(g);
    assign pix_mask[3 - g] = in_body && (lane_addr >= data_offset_q) &&
                             (lane_addr < file_size_q);
  end

  always_comb begin
    state_d       = state_q;
    byte_addr_d   = byte_addr_q;
    file_size_d   = file_size_q;
    data_offset_d = data_offset_q;
    img_width_d   = img_width_q;
    img_height_d  = img_height_q;
    bit_count_d   = bit_count_q;
    hdr_valid_d   = hdr_valid_q;
    fwd           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hdr_valid_d = 1'b0;
          if (sig_ok) begin
            fwd               = 1'b1;
            file_size_d[15:0] = lanes23_le(in_data);
            byte_addr_d       = 32'd4;
            state_d           = ST_HDR;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_HDR: begin
        if (accept) begin
          if ((word_idx == W_CHK) && offset_bad) begin
            state_d = ST_ERR;
          end else begin
            fwd = 1'b1;
            if (word_idx == W_FS + 30'd1) file_size_d[31:16]   = lanes01_le(in_data);
            if (word_idx == W_DO)         data_offset_d[15:0]  = lanes23_le(in_data);
            if (word_idx == W_DO + 30'd1) data_offset_d[31:16] = lanes01_le(in_data);
            if (word_idx == W_IW)         img_width_d[15:0]    = lanes23_le(in_data);
            if (word_idx == W_IW + 30'd1) img_width_d[31:16]   = lanes01_le(in_data);
            if (word_idx == W_IH)         img_height_d[15:0]   = lanes23_le(in_data);
            if (word_idx == W_IH + 30'd1) img_height_d[31:16]  = lanes01_le(in_data);
            if (word_idx == W_BC) begin
              bit_count_d = lanes01_le(in_data);
              hdr_valid_d = 1'b1;
            end
            // A tiny file can end on the same word that starts its pixels.
            if (is_last) begin
              byte_addr_d = '0;
              state_d     = ST_IDLE;
            end else begin
              byte_addr_d = addr_next;
              if (in_body && (addr_next > data_offset_q)) state_d = ST_PIXEL;
            end
          end
        end
      end

      ST_PIXEL: begin
        if (accept) begin
          fwd = 1'b1;
          if (is_last) begin
            byte_addr_d = '0;
            state_d     = ST_IDLE;
          end else begin
            byte_addr_d = addr_next;
          end
        end
      end

      ST_ERR: begin
        // Terminal: input is drained and discarded until reset.
      end

      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      byte_addr_q   <= '0;
      file_size_q   <= '0;
      data_offset_q <= '0;
      img_width_q   <= '0;
      img_height_q  <= '0;
      bit_count_q   <= '0;
      hdr_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_addr_q   <= byte_addr_d;
      file_size_q   <= file_size_d;
      data_offset_q <= data_offset_d;
      img_width_q   <= img_width_d;
      img_height_q  <= img_height_d;
      bit_count_q   <= bit_count_d;
      hdr_valid_q   <= hdr_valid_d;
    end
  end

  bmp_out_slice #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slice (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid_i  (fwd),
    .ld_data_i   (in_data),
    .ld_mask_i   (pix_mask),
    .ld_last_i   (is_last),
    .ld_ready_o  (slice_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_mask_o  (out_pix_mask),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  assign file_size   = file_size_q;
  assign data_offset = data_offset_q;
  assign img_width   = img_width_q;
  assign img_height  = img_height_q;
  assign bit_count   = bit_count_q;
  assign hdr_valid   = hdr_valid_q;
  assign err         = (state_q == ST_ERR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb_bmp_stream_parser: self-checking bench for bmp_stream_parser. A file
// level reference model (byte addresses, header bytes, file word index)
// predicts every forwarded word; a negedge monitor scoreboards the output.
module tb_bmp_stream_parser;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_pix_mask;
  logic        out_last;
  logic [31:0] file_size, data_offset, img_width, img_height;
  logic [15:0] bit_count;
  logic        hdr_valid, err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // out_ready: 0 = always high, 1 = random per cycle, 2 = forced low
  logic [1:0] ready_mode = 2'd0;
  logic       rnd_bit = 1'b1;
  assign out_ready = (ready_mode == 2'd0) ? 1'b1 :
                     (ready_mode == 2'd2) ? 1'b0 : rnd_bit;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  int unsigned cyc = 0;
  int unsigned last_acc_cyc = 0;
  always @(posedge clk) cyc++;

  bmp_stream_parser #(.DATA_WIDTH(32), .MIN_HDR_BYTES(54)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix_mask(out_pix_mask), .out_last(out_last),
    .file_size(file_size), .data_offset(data_offset),
    .img_width(img_width), .img_height(img_height), .bit_count(bit_count),
    .hdr_valid(hdr_valid), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int out_cnt = 0;
  logic [36:0] exp_q[$];     // {data, mask, last}
  logic [31:0] file_w[$];    // current file as stream words

  // ---------------- reference model ----------------
  int         m_k;           // word index within the current file
  logic       m_err;
  logic       m_hdr_valid;
  logic [7:0] m_hdr [0:31];

  function automatic logic [31:0] le32(input int base);
    return {m_hdr[base+3], m_hdr[base+2], m_hdr[base+1], m_hdr[base]};
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_err = 1'b0;
    m_hdr_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_hdr[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [31:0] w, output logic fwd);
    logic [31:0] fsize, doff, a, base;
    logic [3:0]  mask;
    logic        last;
    fwd = 1'b0;
    if (m_err) return;
    if (m_k == 0) begin
      m_hdr_valid = 1'b0;
      if (w[31:16] != 16'h424D) begin
        m_err = 1'b1;
        return;
      end
    end
    if (m_k < 8) for (int i = 0; i < 4; i++) m_hdr[4*m_k+i] = w[31-8*i -: 8];
    fsize = le32(2);
    doff  = le32(10);
    if (m_k == 3 && (doff < 32'd54 || fsize <= doff)) begin
      m_err = 1'b1;
      return;
    end
    if (m_k == 7) m_hdr_valid = 1'b1;
    base = 32'(4 * m_k);
    mask = 4'b0000;
    last = 1'b0;
    if (m_k >= 3) begin
      for (int i = 0; i < 4; i++) begin
        a = base + 32'(i);
        mask[3-i] = (a >= doff) && (a < fsize);
      end
      last = (base + 32'd4 >= fsize);
    end
    exp_q.push_back({w, mask, last});
    fwd = 1'b1;
    if (last) m_k = 0;
    else m_k++;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        hold_prev = 1'b0;
  logic [36:0] hold_val = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_vec++;
        if (!(out_valid === 1'b1 && {out_data, out_pix_mask, out_last} === hold_val)) begin
          n_err++;
          $display("FAIL stall_stable: got v=%b %h/%b/%b want held %h", out_valid,
                   out_data, out_pix_mask, out_last, hold_val);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %h/%b/%b want no word", out_data,
                   out_pix_mask, out_last);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          out_cnt++;
          if ({out_data, out_pix_mask, out_last} !== e) begin
            n_err++;
            $display("FAIL out_word: got %h/%b/%b want %h/%b/%b", out_data, out_pix_mask,
                     out_last, e[36:5], e[4:1], e[0]);
          end
        end
      end
      hold_prev = (out_valid === 1'b1) && !out_ready;
      hold_val  = {out_data, out_pix_mask, out_last};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    ready_mode = 2'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one word, waits (bounded) for acceptance and checks the
  // immediate consequences against the model.
  task automatic send_word(input logic [31:0] w, input int gap);
    logic acc, fwd;
    int   tries;
    if (gap > 0) idle(gap);
    in_data = w;
    in_valid = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want 1", tries);
      return;
    end
    last_acc_cyc = cyc;
    model_accept(w, fwd);
    n_vec++;
    if (err !== m_err) begin
      n_err++;
      $display("FAIL err_flag: got %b want %b", err, m_err);
    end
    n_vec++;
    if (hdr_valid !== m_hdr_valid) begin
      n_err++;
      $display("FAIL hdr_valid: got %b want %b", hdr_valid, m_hdr_valid);
    end
    if (fwd) begin
      n_vec++;
      if (!(out_valid === 1'b1 && out_data === w)) begin
        n_err++;
        $display("FAIL latency: got v=%b d=%h want v=1 d=%h", out_valid, out_data, w);
      end
    end
  endtask

  task automatic send_file(input int first, input int last, input int gap_max);
    for (int k = first; k <= last; k++) send_word(file_w[k], $urandom_range(0, gap_max));
  endtask

  task automatic build_file(input int fsize, input int doff, input int wid,
                            input int hgt, input int bpp);
    logic [7:0] b[$];
    int nb;
    nb = ((fsize + 3) / 4) * 4;
    for (int i = 0; i < nb; i++) b.push_back(8'($urandom_range(0, 255)));
    b[0] = 8'h42;
    b[1] = 8'h4D;
    for (int i = 0; i < 4; i++) begin
      b[2+i]  = 8'(fsize >> (8*i));
      b[6+i]  = 8'h00;
      b[10+i] = 8'(doff >> (8*i));
      b[14+i] = 8'(40 >> (8*i));
      b[18+i] = 8'(wid >> (8*i));
      b[22+i] = 8'(hgt >> (8*i));
    end
    b[26] = 8'd1;
    b[27] = 8'd0;
    b[28] = 8'(bpp);
    b[29] = 8'(bpp >> 8);
    file_w.delete();
    for (int k = 0; k < nb / 4; k++) file_w.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0;
    ready_mode = 2'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, out_data, out_pix_mask, out_last, hdr_valid, err} !== 40'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h m=%b l=%b hv=%b e=%b want all 0",
               out_valid, out_data, out_pix_mask, out_last, hdr_valid, err);
    end
    n_vec++;
    if ({file_size, data_offset, img_width, img_height, bit_count} !== 144'd0) begin
      n_err++;
      $display("FAIL reset_fields: got %0d/%0d/%0d/%0d/%0d want all 0", file_size,
               data_offset, img_width, img_height, bit_count);
    end
    n_vec++;
    if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_ready: got in_ready=%b state=%0d want 1/0", in_ready, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle_quiet: got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input int fs, input int doff,
                              input int wid, input int hgt, input int bpp);
    n_vec++;
    if ({file_size, data_offset, img_width, img_height, bit_count, hdr_valid} !==
        {32'(fs), 32'(doff), 32'(wid), 32'(hgt), 16'(bpp), 1'b1}) begin
      n_err++;
      $display("FAIL fields_%s: got %0d/%0d/%0d/%0d/%0d hv=%b want %0d/%0d/%0d/%0d/%0d hv=1",
               tag, file_size, data_offset, img_width, img_height, bit_count, hdr_valid,
               fs, doff, wid, hgt, bpp);
    end
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    n_vec++;
    if (got != want || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL count_%s: got %0d words (%0d pending) want %0d", tag, got,
               exp_q.size(), want);
    end
  endtask

  task automatic test_min_file();
    int c0;
    do_reset();
    build_file(62, 54, 2, 1, 24);
    c0 = out_cnt;
    send_file(0, 12, 0);
    send_word(file_w[13], 0);
    n_vec++;
    if (out_pix_mask !== 4'b0011 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL mask_w13: got %b/%b want 0011/0", out_pix_mask, out_last);
    end
    send_word(file_w[14], 0);
    send_word(file_w[15], 0);
    n_vec++;
    if (out_pix_mask !== 4'b1100 || out_last !== 1'b1) begin
      n_err++;
      $display("FAIL mask_w15: got %b/%b want 1100/1", out_pix_mask, out_last);
    end
    idle(3);
    check_count("min_file", out_cnt - c0, 16);
    check_fields("min_file", 62, 54, 2, 1, 24);
  endtask

  task automatic test_stall();
    int c0;
    do_reset();
    build_file(62, 54, 2, 1, 24);
    c0 = out_cnt;
    fork
      send_file(0, 15, 0);
      begin
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(posedge clk);
          #1;
          seen = (out_valid === 1'b1) && (out_data === file_w[10]);
        end
        n_vec++;
        if (!seen) begin
          n_err++;
          $display("FAIL stall_find_w10: got no word %h want it within 100 cycles", file_w[10]);
        end else begin
          ready_mode = 2'd2;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0 || out_data !== file_w[10]) begin
              n_err++;
              $display("FAIL stall_backpressure: got rdy=%b d=%h want 0/%h", in_ready,
                       out_data, file_w[10]);
            end
            @(posedge clk);
            #1;
          end
          ready_mode = 2'd0;
        end
      end
    join
    idle(3);
    check_count("stall", out_cnt - c0, 16);
  endtask

  task automatic test_bad_signature();
    int c0;
    do_reset();
    c0 = out_cnt;
    send_word(32'h42580000, 0);
    for (int i = 0; i < 4; i++) send_word($urandom, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1) begin
        n_err++;
        $display("FAIL bad_sig_state: got v=%b rdy=%b err=%b want 0/1/1", out_valid,
                 in_ready, err);
      end
    end
    check_count("bad_sig", out_cnt - c0, 0);
  endtask

  task automatic test_bad_offset();
    int c0;
    do_reset();
    build_file(62, 40, 2, 1, 24);
    c0 = out_cnt;
    send_file(0, 7, 0);
    idle(3);
    n_vec++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bad_offset_err: got err=%b rdy=%b want 1/1", err, in_ready);
    end
    check_count("bad_offset", out_cnt - c0, 3);
  endtask

  task automatic test_back_to_back();
    int c0;
    int unsigned end_a;
    do_reset();
    c0 = out_cnt;
    build_file(62, 54, 2, 1, 24);
    send_file(0, 15, 0);
    end_a = last_acc_cyc;
    build_file(62, 54, 2, 1, 24);
    send_word(file_w[0], 0);
    n_vec++;
    if (last_acc_cyc != end_a + 1 || hdr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_word0: got cycle +%0d hv=%b want +1 hv=0", last_acc_cyc - end_a,
               hdr_valid);
    end
    send_file(1, 15, 0);
    idle(3);
    check_count("b2b", out_cnt - c0, 32);
    check_fields("b2b", 62, 54, 2, 1, 24);

    // Reset pulsed while word 9 is being presented.
    build_file(62, 54, 2, 1, 24);
    send_file(0, 8, 0);
    in_data = file_w[9];
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, hdr_valid, err, file_size, in_ready} !== {3'b000, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b hv=%b e=%b fs=%0d rdy=%b want 0/0/0/0/1",
               out_valid, hdr_valid, err, file_size, in_ready);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    c0 = out_cnt;
    build_file(70, 58, 3, 2, 16);
    send_file(0, file_w.size() - 1, 0);
    idle(3);
    check_count("after_reset", out_cnt - c0, file_w.size());
    check_fields("after_reset", 70, 58, 3, 2, 16);
  endtask

  task automatic test_random();
    int c0, nw, fs, doff, wid, hgt, bpp;
    do_reset();
    ready_mode = 2'd1;
    c0 = out_cnt;
    nw = 0;
    for (int f = 0; f < 7; f++) begin
      if (f == 0) begin
        doff = 54;
        fs = 55;
      end else begin
        doff = $urandom_range(54, 80);
        fs = doff + $urandom_range(1, 70);
      end
      wid = $urandom_range(1, 5000);
      hgt = $urandom_range(1, 5000);
      bpp = (f % 2 == 0) ? 24 : 32;
      build_file(fs, doff, wid, hgt, bpp);
      nw += file_w.size();
      send_file(0, file_w.size() - 1, (f % 3 == 0) ? 0 : 2);
    end
    ready_mode = 2'd0;
    idle(4);
    check_count("random", out_cnt - c0, nw);
    check_fields("random_last", fs, doff, wid, hgt, bpp);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_min_file();
    test_stall();
    test_bad_signature();
    test_bad_offset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
